// File: rtl/divider_r2_pkg.sv
// rtl/divider_r2_pkg.sv - shared state encoding and counter sizing for the radix-2 divider
package divider_r2_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    // Iteration counter must hold W-1; keep at least one bit for tiny widths.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/divider_r2_step.sv
// rtl/divider_r2_step.sv - one combinational restoring-division iteration
module divider_r2_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] div,
    output logic [W-1:0] rem_nxt,
    output logic [W-1:0] quo_nxt
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // trial stays W+1 wide: rem < div guarantees its MSB is a clean borrow flag.
    always_comb begin
        shifted = {rem, quo[W-1]};
        trial   = shifted - {1'b0, div};
        if (!trial[W]) begin
            rem_nxt = trial[W-1:0];
            quo_nxt = {quo[W-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[W-1:0];
            quo_nxt = {quo[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_r2.sv
// rtl/divider_r2.sv - multi-cycle radix-2 restoring divider, W+2 cycles per op
// Optional signed operation when DIVIDER_R2_SIGNED_EN is defined.
module divider_r2
    import divider_r2_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         pass,
    output logic [W-1:0] y,
    output logic [W-1:0] r,
    output logic         div0_r,
    output logic         y_vld_r,
    output logic         busy_r
);

    localparam int CW = cnt_width(W);

    state_t         state;
    logic [CW-1:0]  count_r;
    logic [W-1:0]   quo_r;
    logic [W-1:0]   rem_r;
    logic [W-1:0]   div_r;
    logic [W-1:0]   rem_nxt;
    logic [W-1:0]   quo_nxt;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic [W-1:0]   res_y;
    logic [W-1:0]   res_r;

`ifdef DIVIDER_R2_SIGNED_EN
    logic           sign_a;
    logic           sign_b;
    logic [W-1:0]   a_raw;

    // Divide magnitudes; the most negative value maps onto itself, which is its correct magnitude.
    always_comb begin
        a_in = a[W-1] ? (~a + 1'b1) : a;
        b_in = b[W-1] ? (~b + 1'b1) : b;
    end

    always_comb begin
        res_y = '1;
        res_r = a_raw;
        if (div_r != '0) begin
            res_y = (sign_a ^ sign_b) ? (~quo_r + 1'b1) : quo_r;
            res_r = sign_a ? (~rem_r + 1'b1) : rem_r;
        end
    end
`else
    always_comb begin
        a_in  = a;
        b_in  = b;
        res_y = quo_r;
        res_r = rem_r;
    end
`endif

    divider_r2_step #(.W(W)) u_step (
        .rem     (rem_r),
        .quo     (quo_r),
        .div     (div_r),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            count_r <= '0;
            quo_r   <= '0;
            rem_r   <= '0;
            div_r   <= '0;
            y       <= '0;
            r       <= '0;
            div0_r  <= 1'b0;
            y_vld_r <= 1'b0;
            busy_r  <= 1'b0;
`ifdef DIVIDER_R2_SIGNED_EN
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            a_raw   <= '0;
`endif
        end else begin
            y_vld_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pass) begin
                        quo_r   <= a_in;
                        div_r   <= b_in;
                        rem_r   <= '0;
                        count_r <= CW'(W - 1);
                        state   <= S_RUN;
                        busy_r  <= 1'b1;
`ifdef DIVIDER_R2_SIGNED_EN
                        sign_a  <= a[W-1];
                        sign_b  <= b[W-1];
                        a_raw   <= a;
`endif
                    end
                end
                S_RUN: begin
                    rem_r   <= rem_nxt;
                    quo_r   <= quo_nxt;
                    count_r <= count_r - CW'(1);
                    if (count_r == '0) begin
                        state <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    y       <= res_y;
                    r       <= res_r;
                    div0_r  <= (div_r == '0);
                    y_vld_r <= 1'b1;
                    state   <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_r2.sv
// tb/tb_divider_r2.sv - scoreboard bench for divider_r2 (W=32)
module tb_divider_r2;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         pass;
    logic [W-1:0] y;
    logic [W-1:0] r;
    logic         div0_r;
    logic         y_vld_r;
    logic         busy_r;

    typedef struct {
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic         d0;
        int           start;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    divider_r2 #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .pass    (pass),
        .y       (y),
        .r       (r),
        .div0_r  (div0_r),
        .y_vld_r (y_vld_r),
        .busy_r  (busy_r)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, output exp_t e);
`ifdef DIVIDER_R2_SIGNED_EN
        longint sa;
        longint sbv;
        longint q;
        longint m;
`endif
        e.d0 = (ib == '0);
        e.start = 0;
        if (ib == '0) begin
            e.y = '1;
            e.r = ia;
        end else begin
`ifdef DIVIDER_R2_SIGNED_EN
            sa  = longint'($signed(ia));
            sbv = longint'($signed(ib));
            q   = sa / sbv;
            m   = sa % sbv;
            e.y = q[W-1:0];
            e.r = m[W-1:0];
`else
            e.y = ia / ib;
            e.r = ia % ib;
`endif
        end
    endtask

    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib);
        exp_t e;
        model(ia, ib, e);
        e.start = cyc;
        sb.push_back(e);
        a    = ia;
        b    = ib;
        pass = 1'b1;
        @(posedge clk);
        #1;
        pass = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && y_vld_r === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_vld", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("y", 64'(y), 64'(e.y));
                check("r", 64'(r), 64'(e.r));
                check("div0_r", 64'(div0_r), 64'(e.d0));
                check("latency", 64'(cyc - e.start), 64'(LAT));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        a    = '0;
        b    = '0;
        pass = 1'b0;
        @(posedge clk);
        #1;
        check("rst_y", 64'(y), 64'd0);
        check("rst_r", 64'(r), 64'd0);
        check("rst_div0", 64'(div0_r), 64'd0);
        check("rst_vld", 64'(y_vld_r), 64'd0);
        check("rst_busy", 64'(busy_r), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic op with busy profile
        start_op(32'd100, 32'd7);
        check("busy_c1", 64'(busy_r), 64'd1);
        repeat (32) @(posedge clk);
        #1;
        check("busy_c33", 64'(busy_r), 64'd1);
        @(posedge clk);
        #1;
        check("busy_c34", 64'(busy_r), 64'd0);
        check("vld_c34", 64'(y_vld_r), 64'd1);
        @(posedge clk);
        #1;
        check("vld_c35", 64'(y_vld_r), 64'd0);
        wait_drain();

        // Max dividend, then back-to-back in the valid cycle with a < b
        start_op(32'hFFFF_FFFF, 32'd1);
        repeat (33) @(posedge clk);
        #1;
        start_op(32'd5, 32'd10);
        wait_drain();

        // Divide by zero
        start_op(32'd5, 32'd0);
        wait_drain();

        // pass and operand changes while busy are ignored
        start_op(32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        a    = 32'd9;
        b    = 32'd3;
        pass = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        pass = 1'b0;
        wait_drain();
        repeat (5) @(posedge clk);
        #1;

        // Async reset mid-operation abandons the op
        start_op(32'd123456, 32'd789);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("arst_y", 64'(y), 64'd0);
        check("arst_r", 64'(r), 64'd0);
        check("arst_busy", 64'(busy_r), 64'd0);
        check("arst_vld", 64'(y_vld_r), 64'd0);
        check("arst_div0", 64'(div0_r), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        start_op(32'd1000, 32'd33);
        wait_drain();

        // Random operands, mix of small and full-range divisors
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = (i % 2 == 1) ? $urandom : $urandom_range(1, 300);
            start_op(ra, rb);
            wait_drain();
        end

`ifdef DIVIDER_R2_SIGNED_EN
        start_op(32'hFFFF_FFF9, 32'd2);
        wait_drain();
        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        wait_drain();
        start_op(32'hFFFF_FF9C, 32'd7);
        wait_drain();
        start_op(32'hFFFF_FFF9, 32'd0);
        wait_drain();
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
